// File: rtl/aes_pkg.sv
// Shared AES column types, MixColumns matrix rows and constant-multiplier GF(2^8) helpers.
package aes_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned COL_W  = 32;
    localparam int unsigned ROWS   = 4;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [COL_W-1:0]  col_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } mix_state_e;

    // First matrix row, most significant byte multiplies row 0 of the input column
    localparam col_t INV_MIX_ROW0 = 32'h0E0B0D09;
    localparam col_t FWD_MIX_ROW0 = 32'h02030101;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Only the multipliers used by the forward and inverse matrices are supported
    function automatic byte_t gmul_const(input byte_t m, input byte_t b);
        byte_t x2;
        byte_t x4;
        byte_t x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (m)
            8'h01:   return b;
            8'h02:   return x2;
            8'h03:   return x2 ^ b;
            8'h09:   return x8 ^ b;
            8'h0B:   return x8 ^ x2 ^ b;
            8'h0D:   return x8 ^ x4 ^ b;
            8'h0E:   return x8 ^ x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/inv_mix_col.sv
// Combinational single-column InvMixColumns; with INV_MIX_FWD_EN the fwd input selects forward MixColumns.
module inv_mix_col
    import aes_pkg::*;
(
`ifdef INV_MIX_FWD_EN
    input  logic fwd,
`endif
    input  col_t col_in,
    output col_t col_out
);

    col_t  coeffs;
    byte_t a [ROWS];
    byte_t acc;

    // Row r uses row 0 rotated right by r: M[r][j] = row0[(j - r) mod 4]
    always_comb begin
        coeffs = INV_MIX_ROW0;
`ifdef INV_MIX_FWD_EN
        if (fwd) begin
            coeffs = FWD_MIX_ROW0;
        end
`endif
        col_out = '0;
        acc     = '0;
        for (int j = 0; j < ROWS; j++) begin
            a[j] = col_in[COL_W-1-BYTE_W*j -: BYTE_W];
        end
        for (int r = 0; r < ROWS; r++) begin
            acc = '0;
            for (int j = 0; j < ROWS; j++) begin
                acc = acc ^ gmul_const(coeffs[COL_W-1-BYTE_W*((j-r+ROWS)%ROWS) -: BYTE_W], a[j]);
            end
            col_out[COL_W-1-BYTE_W*r -: BYTE_W] = acc;
        end
    end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns engine, one column per cycle over a shared column unit.
// Optional INV_MIX_FWD_EN adds fwd_i to select the forward MixColumns matrix per block.
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned NUM_COLS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
`ifdef INV_MIX_FWD_EN
    input  logic                    fwd_i,
`endif
    output logic                    in_ready,
    input  logic [32*NUM_COLS-1:0]  state_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [32*NUM_COLS-1:0]  state_out,
    output logic                    busy
);

    localparam int unsigned CNT_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned STATE_W = COL_W * NUM_COLS;
    localparam int unsigned RES_W   = STATE_W - COL_W;

    mix_state_e         state;
    logic [CNT_W-1:0]   col_cnt;
    logic [STATE_W-1:0] src;
    logic [RES_W-1:0]   res;
    col_t               cur_col;
    col_t               mixed_col;
    logic               last_col;
`ifdef INV_MIX_FWD_EN
    logic               fwd_q;
`endif

    assign in_ready = (state == ST_IDLE) && !rst;

    // Source shifts left one column per RUN cycle, so the active column is always on top
    assign cur_col  = src[STATE_W-1 -: COL_W];
    assign last_col = (col_cnt == CNT_W'(NUM_COLS - 1));

    inv_mix_col u_col (
`ifdef INV_MIX_FWD_EN
        .fwd     (fwd_q),
`endif
        .col_in  (cur_col),
        .col_out (mixed_col)
    );

    // Results shift in from the bottom; the final column completes the state on the last edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            col_cnt   <= '0;
            src       <= '0;
            res       <= '0;
            out_valid <= 1'b0;
            state_out <= '0;
            busy      <= 1'b0;
`ifdef INV_MIX_FWD_EN
            fwd_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        src     <= state_in;
                        col_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ST_RUN;
`ifdef INV_MIX_FWD_EN
                        fwd_q   <= fwd_i;
`endif
                    end
                end
                ST_RUN: begin
                    src     <= {src[STATE_W-COL_W-1:0], COL_W'(0)};
                    res     <= {res[RES_W-COL_W-1:0], mixed_col};
                    col_cnt <= col_cnt + CNT_W'(1);
                    if (last_col) begin
                        state_out <= {res, mixed_col};
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed self-checking bench for inv_mix_columns_seq with an independent GF(2^8) reference model.
module tb_inv_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;
`ifdef INV_MIX_FWD_EN
    logic         fwd_i;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] VEC1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] VEC1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] VEC2_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] VEC2_OUT = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

    always #5 clk = ~clk;

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
`ifdef INV_MIX_FWD_EN
        .fwd_i     (fwd_i),
`endif
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    // Shift-and-add multiply, independent of the xtime chains in the design
    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] s, input bit fwd);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        logic [7:0]   m0, m1, m2, m3;
        r = '0;
        if (fwd) begin
            m0 = 8'h02; m1 = 8'h03; m2 = 8'h01; m3 = 8'h01;
        end else begin
            m0 = 8'h0e; m1 = 8'h0b; m2 = 8'h0d; m3 = 8'h09;
        end
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gf_mul(a0, m0) ^ gf_mul(a1, m1) ^ gf_mul(a2, m2) ^ gf_mul(a3, m3);
            r[119-32*c -: 8] = gf_mul(a0, m3) ^ gf_mul(a1, m0) ^ gf_mul(a2, m1) ^ gf_mul(a3, m2);
            r[111-32*c -: 8] = gf_mul(a0, m2) ^ gf_mul(a1, m3) ^ gf_mul(a2, m0) ^ gf_mul(a3, m1);
            r[103-32*c -: 8] = gf_mul(a0, m1) ^ gf_mul(a1, m2) ^ gf_mul(a2, m3) ^ gf_mul(a3, m0);
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then holds in_valid across exactly one accept edge
    task automatic send(input logic [127:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            state_in = s;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
    endtask

    // Counts edges after the accept edge until out_valid; -1 if it never rises
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
`ifdef INV_MIX_FWD_EN
        fwd_i     = 1'b0;
`endif
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (state_out !== 128'h0) begin errors++; $display("FAIL reset_state_out got=%h exp=0", state_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during_rst got=%b exp=0", in_ready); end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_inverse_vectors;
        logic [127:0] vin  [2];
        logic [127:0] vout [2];
        bit ok;
        int lat;
        vin[0] = VEC1_IN;  vout[0] = VEC1_OUT;
        vin[1] = VEC2_IN;  vout[1] = VEC2_OUT;
        for (int v = 0; v < 2; v++) begin
            send(vin[v], ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL vec%0d_accept_timeout got=0 exp=1", v); end
            checks++;
            if ({busy, in_ready, out_valid} !== 3'b100) begin
                errors++; $display("FAIL vec%0d_run_flags busy/in_ready/out_valid got=%b exp=100", v, {busy, in_ready, out_valid});
            end
            wait_done(lat);
            checks++;
            if (lat !== 4) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=4", v, lat); end
            checks++;
            if (state_out !== vout[v]) begin errors++; $display("FAIL vec%0d_result got=%h exp=%h", v, state_out, vout[v]); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++;
            if ({busy, in_ready, out_valid} !== 3'b010) begin
                errors++; $display("FAIL vec%0d_post_handshake busy/in_ready/out_valid got=%b exp=010", v, {busy, in_ready, out_valid});
            end
            checks++;
            if (state_out !== vout[v]) begin errors++; $display("FAIL vec%0d_hold_after_handshake got=%h exp=%h", v, state_out, vout[v]); end
        end
    endtask

    task automatic test_stall;
        bit ok;
        int lat;
        int bad;
        send(VEC2_IN, ok);
        wait_done(lat);
        checks++;
        if (!ok || lat !== 4) begin errors++; $display("FAIL stall_setup ok=%0d lat=%0d exp ok=1 lat=4", ok, lat); end
        state_in = VEC1_IN;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || state_out !== VEC2_OUT || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_hold bad_cycles got=%0d exp=0 state_out=%h", bad, state_out); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL stall_release out_valid/in_ready got=%b exp=01", {out_valid, in_ready}); end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_no_queued_block bad_cycles got=%0d exp=0", bad); end
        checks++;
        if (state_out !== VEC2_OUT) begin errors++; $display("FAIL stall_state_out_kept got=%h exp=%h", state_out, VEC2_OUT); end
    endtask

    task automatic test_abort;
        bit ok;
        int bad;
        send(VEC1_IN, ok);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (!ok || in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready_in_rst ok=%0d got=%b exp=0", ok, in_ready); end
        tick();
        checks++;
        if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL abort_flags out_valid/busy got=%b exp=00", {out_valid, busy}); end
        checks++;
        if (state_out !== 128'h0) begin errors++; $display("FAIL abort_state_out got=%h exp=0", state_out); end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready_after got=%b exp=1", in_ready); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_partial_presented got=%0d exp=0", bad); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] s;
        logic [127:0] exp;
        bit ok;
        int lat;
        for (int n = 0; n < 40; n++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            if (n == 0) s = 128'h00000000_ffffffff_5a5a5a5a_01020304;
            exp = model_mix(s, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
            send(s, ok);
            wait_done(lat);
            checks++;
            if (!ok || lat !== 4) begin errors++; $display("FAIL b2b%0d_timing ok=%0d lat=%0d exp ok=1 lat=4", n, ok, lat); end
            checks++;
            if (state_out !== exp) begin errors++; $display("FAIL b2b%0d_result got=%h exp=%h", n, state_out, exp); end
            repeat ($urandom_range(0, 3)) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

`ifdef INV_MIX_FWD_EN
    task automatic test_forward;
        logic [127:0] s;
        logic [127:0] mid;
        bit ok;
        int lat;
        fwd_i = 1'b1;
        send(VEC1_OUT, ok);
        fwd_i = 1'b0;
        wait_done(lat);
        checks++;
        if (!ok || lat !== 4 || state_out !== VEC1_IN) begin
            errors++; $display("FAIL fwd_vector lat=%0d got=%h exp=%h", lat, state_out, VEC1_IN);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        for (int n = 0; n < 10; n++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            fwd_i = 1'b1;
            send(s, ok);
            fwd_i = 1'b0;
            wait_done(lat);
            mid = state_out;
            out_ready = 1'b1; tick(); out_ready = 1'b0;
            send(mid, ok);
            wait_done(lat);
            checks++;
            if (state_out !== s) begin errors++; $display("FAIL fwd_roundtrip%0d got=%h exp=%h", n, state_out, s); end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
`ifdef INV_MIX_FWD_EN
        fwd_i     = 1'b0;
`endif
        test_reset();
        test_inverse_vectors();
        test_stall();
        test_abort();
        test_back_to_back();
`ifdef INV_MIX_FWD_EN
        test_forward();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
